// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file: round-robin grant between the ALU and
// load/CSR writeback ports, one registered write per cycle, and a busy scoreboard for hazard checks.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,

  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,

  input  logic        hold,

  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,

  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2,

  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic        prio_q, prio_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic [31:0] busy_q, busy_d;

  logic        arb_en;
  logic        a_gnt, b_gnt;
  logic        xfer;
  logic        gnt_wr;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic [31:0] set_vec, clr_vec;

  // Grants are purely combinational; rst_n gating keeps both readys low during reset.
  always_comb begin
    arb_en = rst_n & ~hold;
    a_gnt  = arb_en & a_valid & (~b_valid | ~prio_q);
    b_gnt  = arb_en & b_valid & (~a_valid |  prio_q);
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  always_comb begin
    xfer     = a_gnt | b_gnt;
    gnt_addr = b_gnt ? b_addr : a_addr;
    gnt_data = b_gnt ? b_data : a_data;
    gnt_wr   = xfer & (gnt_addr != 5'd0);
  end

  always_comb begin
    prio_d  = prio_q;
    rf_we_d = gnt_wr;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (xfer) begin
      prio_d = a_gnt;
    end
    // Writes to x0 are accepted but dropped; the address/data outputs keep the last real write.
    if (gnt_wr) begin
      rf_wa_d = gnt_addr;
      rf_wd_d = gnt_data;
    end
  end

  // Per-register scoreboard bit: an issue on the same edge outranks a retiring write.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign set_vec[gi] = 1'b0;
        assign clr_vec[gi] = 1'b0;
        assign busy_d[gi]  = 1'b0;
      end else begin : g_reg
        assign set_vec[gi] = iss_valid & (iss_addr == 5'(gi));
        assign clr_vec[gi] = gnt_wr & (gnt_addr == 5'(gi));
        assign busy_d[gi]  = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      rf_we_q <= 1'b0;
      rf_wa_q <= 5'd0;
      rf_wd_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      prio_q  <= prio_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  assign chk_busy1 = rst_n & busy_q[chk_addr1];
  assign chk_busy2 = rst_n & busy_q[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        hold = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [4:0]  chk_addr1 = '0, chk_addr2 = '0;
  logic        chk_busy1, chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic        m_prio_b;     // 1: B wins a tie
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_known;      // rf_wa/rf_wd are defined (no x0 write since the last real write)
  logic        e_a, e_b;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  initial begin
    m_prio_b = 1'b0; m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_known = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prio_b = 1'b0; m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_known = 1'b1;
      check("rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
      check("rst_chk_busy1", {31'd0, chk_busy1}, 32'd0);
      check("rst_chk_busy2", {31'd0, chk_busy2}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
      check("rst_rf_wd", rf_wd, 32'd0);
    end else begin
      if (hold) begin
        e_a = 1'b0; e_b = 1'b0;
      end else if (a_valid && b_valid) begin
        e_a = !m_prio_b; e_b = m_prio_b;
      end else begin
        e_a = a_valid; e_b = b_valid;
      end
      check("m_a_ready", {31'd0, a_ready}, {31'd0, e_a});
      check("m_b_ready", {31'd0, b_ready}, {31'd0, e_b});
      check("m_chk_busy1", {31'd0, chk_busy1}, {31'd0, m_busy[chk_addr1]});
      check("m_chk_busy2", {31'd0, chk_busy2}, {31'd0, m_busy[chk_addr2]});
      check("m_rf_we", {31'd0, rf_we}, {31'd0, m_we});
      if (m_known) begin
        check("m_rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
        check("m_rf_wd", rf_wd, m_wd);
      end
      // Apply this cycle's events to the model.
      m_we = 1'b0;
      if (e_a || e_b) begin
        w_addr   = e_a ? a_addr : b_addr;
        w_data   = e_a ? a_data : b_data;
        m_prio_b = e_a;
        if (w_addr != 5'd0) begin
          m_busy[w_addr] = 1'b0;
          m_we = 1'b1; m_wa = w_addr; m_wd = w_data; m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
      if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  logic a_took, b_took;

  initial begin
    // Reset held: requests must not be granted.
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (3) step();
    check("rst_hold_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_hold_rf_we", {31'd0, rf_we}, 32'd0);

    // Alternating grants A,B,A,B,A from A-first.
    $display("scenario: round-robin a_addr=3 b_addr=4");
    rst_n = 1'b1;
    a_addr = 5'd3; b_addr = 5'd4; a_data = 32'h0000_00A0; b_data = 32'h0000_00B0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_a_ready", {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", {31'd0, b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check("rr_rf_we", {31'd0, rf_we}, 32'd1);
      check("rr_rf_wa", {27'd0, rf_wa}, (k % 2 == 0) ? 32'd3 : 32'd4);
      check("rr_rf_wd", rf_wd, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      #1;
    end

    // Last grant was A, so B is first once hold drops.
    $display("scenario: hold for 3 cycles with both valid");
    hold = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("hold_a_ready", {31'd0, a_ready}, 32'd0);
      check("hold_b_ready", {31'd0, b_ready}, 32'd0);
      step();
      check("hold_rf_we", {31'd0, rf_we}, 32'd0);
    end
    hold = 1'b0;
    #1;
    check("unhold_b_ready", {31'd0, b_ready}, 32'd1);
    check("unhold_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    check("unhold_rf_wa", {27'd0, rf_wa}, 32'd4);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Issue r7, retire it through port B three cycles later.
    $display("scenario: issue r7, B writes r7=0xDEADBEEF");
    iss_valid = 1'b1; iss_addr = 5'd7; chk_addr1 = 5'd7;
    #1;
    check("iss7_c0_busy", {31'd0, chk_busy1}, 32'd0);
    step();
    iss_valid = 1'b0;
    check("iss7_c1_busy", {31'd0, chk_busy1}, 32'd1);
    step();
    check("iss7_c2_busy", {31'd0, chk_busy1}, 32'd1);
    step();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hDEAD_BEEF;
    #1;
    check("wb7_b_ready", {31'd0, b_ready}, 32'd1);
    check("wb7_c3_busy", {31'd0, chk_busy1}, 32'd1);
    step();
    b_valid = 1'b0;
    check("wb7_rf_we", {31'd0, rf_we}, 32'd1);
    check("wb7_rf_wa", {27'd0, rf_wa}, 32'd7);
    check("wb7_rf_wd", rf_wd, 32'hDEAD_BEEF);
    check("wb7_c4_busy", {31'd0, chk_busy1}, 32'd0);

    // Same-edge set and clear of r5: set wins. Then set r6 while clearing r5.
    $display("scenario: same-edge set/clear on r5, then set r6 + clear r5");
    iss_valid = 1'b1; iss_addr = 5'd5; chk_addr1 = 5'd5; chk_addr2 = 5'd6;
    step();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55;
    #1;
    check("ss5_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    check("ss5_busy", {31'd0, chk_busy1}, 32'd1);
    check("ss5_rf_wa", {27'd0, rf_wa}, 32'd5);
    iss_addr = 5'd6;
    step();
    iss_valid = 1'b0; a_valid = 1'b0;
    check("diff_busy5", {31'd0, chk_busy1}, 32'd0);
    check("diff_busy6", {31'd0, chk_busy2}, 32'd1);

    // Write to x0 is accepted and dropped.
    $display("scenario: A writes x0=0x1234");
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234;
    #1;
    check("x0_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    check("x0_rf_we", {31'd0, rf_we}, 32'd0);
    check("x0_busy6", {31'd0, chk_busy2}, 32'd1);

    // Reset pulse between edges with r9 busy and a write in flight.
    $display("scenario: reset pulse with r9 busy and write in flight");
    iss_valid = 1'b1; iss_addr = 5'd9; chk_addr1 = 5'd9;
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h22;
    #1;
    check("r9_busy", {31'd0, chk_busy1}, 32'd1);
    step();
    a_valid = 1'b0;
    check("r9_rf_we", {31'd0, rf_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    check("arst_rf_we", {31'd0, rf_we}, 32'd0);
    check("arst_rf_wa", {27'd0, rf_wa}, 32'd0);
    check("arst_rf_wd", rf_wd, 32'd0);
    check("arst_busy9", {31'd0, chk_busy1}, 32'd0);
    check("arst_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    rst_n = 1'b1; iss_valid = 1'b0;
    #1;
    check("rel_busy9", {31'd0, chk_busy1}, 32'd0);
    check("rel_a_ready", {31'd0, a_ready}, 32'd1);
    check("rel_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    check("rel_rf_wa", {27'd0, rf_wa}, 32'd2);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Randomized traffic; an unaccepted request stays stable until granted.
    $display("scenario: randomized traffic");
    a_took = 1'b0; b_took = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        #1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_took = 1'b0; b_took = 1'b0;
      end
      if (!a_valid || a_took) begin
        a_valid = ($urandom_range(2) != 0);
        a_addr  = 5'($urandom_range(15));
        a_data  = $urandom;
      end
      if (!b_valid || b_took) begin
        b_valid = ($urandom_range(2) != 0);
        b_addr  = 5'($urandom_range(15));
        b_data  = $urandom;
      end
      hold      = ($urandom_range(7) == 0);
      iss_valid = ($urandom_range(1) == 1);
      iss_addr  = 5'($urandom_range(15));
      chk_addr1 = 5'($urandom_range(15));
      chk_addr2 = 5'($urandom);
      #1;
      a_took = a_valid && a_ready;
      b_took = b_valid && b_ready;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
